// File: rtl/mem_arbiter_ctrl_pkg.sv
// mem_arbiter_ctrl_pkg: shared state and grant types for the memory arbiter
package mem_arbiter_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, DATA_RD, DATA_WR, FETCH, WAIT} mem_arb_state_t;
  typedef enum logic {GNT_DATA, GNT_FETCH} mem_arb_grant_t;
endpackage

// File: rtl/rd_latency_pipe.sv
// rd_latency_pipe: delays a read tag by the memory latency so returning data lands in the right slot
module rd_latency_pipe #(
  parameter int MEM_LAT = 1,
  parameter int IDXW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_v,
  input  logic [IDXW-1:0] in_idx,
  output logic            out_v,
  output logic [IDXW-1:0] out_idx
);
  logic [MEM_LAT-1:0] v;
  logic [IDXW-1:0] idx [MEM_LAT];
  always_ff @(posedge clk) begin
    if (rst) v <= '0;
    else begin
      v[0] <= in_v;
      for (int k = 1; k < MEM_LAT; k++) v[k] <= v[k-1];
    end
    idx[0] <= in_idx;
    for (int k = 1; k < MEM_LAT; k++) idx[k] <= idx[k-1];
  end
  assign out_v = v[MEM_LAT-1];
  assign out_idx = idx[MEM_LAT-1];
endmodule

// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: arbitrates CPU fetch bursts and data load/store onto one single-port memory
module mem_arbiter_ctrl
  import mem_arbiter_ctrl_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int FETCH_WORDS = 2,
  parameter int MEM_LAT = 1,
  parameter int FAIR = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      d_req_valid,
  output logic                      d_req_ready,
  input  logic                      d_we,
  input  logic [AW-1:0]             d_addr,
  input  logic [DW-1:0]             d_wdata,
  output logic                      d_rsp_valid,
  output logic [DW-1:0]             d_rsp_data,
  input  logic                      f_req_valid,
  output logic                      f_req_ready,
  input  logic [AW-1:0]             f_addr,
  output logic                      f_rsp_valid,
  output logic [FETCH_WORDS*DW-1:0] f_rsp_data,
  output logic                      mem_we,
  output logic [AW-1:0]             mem_addr,
  output logic [DW-1:0]             mem_wdata,
  input  logic [DW-1:0]             mem_rdata
);
  localparam int IDXW = FETCH_WORDS > 1 ? $clog2(FETCH_WORDS) : 1;
  localparam int CW = $clog2(FETCH_WORDS + 1);
  mem_arb_state_t state;
  mem_arb_grant_t last;
  logic [CW-1:0] cnt;
  logic [AW-1:0] base;
  logic iss_v, ret_v;
  logic [IDXW-1:0] iss_idx, ret_idx;
  logic idle, pick_d, take_d, take_f;
  // the losing channel's ready is dropped so only the winner handshakes on a tie
  always_comb begin
    idle = state == IDLE && !rst;
    pick_d = d_req_valid && (!f_req_valid || FAIR == 0 || last == GNT_FETCH);
    take_d = idle && pick_d;
    take_f = idle && f_req_valid && !pick_d;
  end
  assign d_req_ready = idle && (!d_req_valid || pick_d);
  assign f_req_ready = idle && (!f_req_valid || !pick_d);
  rd_latency_pipe #(.MEM_LAT(MEM_LAT), .IDXW(IDXW)) u_pipe (
    .clk(clk), .rst(rst), .in_v(iss_v), .in_idx(iss_idx), .out_v(ret_v), .out_idx(ret_idx)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last <= GNT_FETCH;
      cnt <= '0;
      base <= '0;
      iss_v <= 1'b0;
      iss_idx <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      d_rsp_valid <= 1'b0;
      d_rsp_data <= '0;
      f_rsp_valid <= 1'b0;
      f_rsp_data <= '0;
    end else begin
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      iss_v <= 1'b0;
      d_rsp_valid <= 1'b0;
      f_rsp_valid <= 1'b0;
      if (take_d) begin
        state <= d_we ? DATA_WR : DATA_RD;
        last <= GNT_DATA;
        mem_we <= d_we;
        mem_addr <= d_addr;
        mem_wdata <= d_we ? d_wdata : '0;
        iss_v <= !d_we;
        iss_idx <= '0;
      end else if (take_f) begin
        state <= FETCH;
        last <= GNT_FETCH;
        base <= f_addr;
        cnt <= CW'(1);
        mem_addr <= f_addr;
        iss_v <= 1'b1;
        iss_idx <= '0;
      end else if (state == DATA_WR) state <= IDLE;
      else if (state == FETCH) begin
        if (cnt == CW'(FETCH_WORDS)) state <= WAIT;
        else begin
          mem_addr <= base + AW'(cnt);
          iss_v <= 1'b1;
          iss_idx <= IDXW'(cnt);
          cnt <= cnt + 1'b1;
        end
      end
      // returning words belong to whichever channel holds the current grant
      if (ret_v) begin
        if (last == GNT_DATA) begin
          d_rsp_data <= mem_rdata;
          d_rsp_valid <= 1'b1;
          state <= IDLE;
        end else begin
          f_rsp_data[ret_idx*DW +: DW] <= mem_rdata;
          if (ret_idx == IDXW'(FETCH_WORDS - 1)) begin
            f_rsp_valid <= 1'b1;
            state <= IDLE;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb_mem_arbiter_ctrl: runs a MEM_LAT=1/FAIR=0 and a MEM_LAT=3/FAIR=1 instance side by side
module tb_mem_arbiter_ctrl;
  typedef struct {int id; int c; logic [31:0] d;} exp_t;
  logic clk = 0, rst = 1;
  logic d_req_valid = 0, d_we = 0, f_req_valid = 0;
  logic [15:0] d_addr = 0, d_wdata = 0, f_addr = 0;
  logic d_rdy0, f_rdy0, d_rv0, f_rv0, we0, d_rdy1, f_rdy1, d_rv1, f_rv1, we1;
  logic [15:0] d_rd0, a0, wd0, rd0, d_rd1, a1, wd1, rd1;
  logic [31:0] f_rd0, f_rd1;
  logic [15:0] m0 [0:65535];
  logic [15:0] m1 [0:65535];
  logic [15:0] p0;
  logic [15:0] p1 [3];
  int cyc = 0, total = 0, bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (we0) m0[a0] <= wd0;
    p0 <= m0[a0];
  end
  always @(posedge clk) begin
    if (we1) m1[a1] <= wd1;
    p1[0] <= m1[a1];
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign rd0 = p0;
  assign rd1 = p1[2];

  mem_arbiter_ctrl #(.MEM_LAT(1), .FAIR(0)) u_dut0 (
    .clk(clk), .rst(rst), .d_req_valid(d_req_valid), .d_req_ready(d_rdy0), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rsp_valid(d_rv0), .d_rsp_data(d_rd0),
    .f_req_valid(f_req_valid), .f_req_ready(f_rdy0), .f_addr(f_addr), .f_rsp_valid(f_rv0),
    .f_rsp_data(f_rd0), .mem_we(we0), .mem_addr(a0), .mem_wdata(wd0), .mem_rdata(rd0)
  );
  mem_arbiter_ctrl #(.MEM_LAT(3), .FAIR(1)) u_dut1 (
    .clk(clk), .rst(rst), .d_req_valid(d_req_valid), .d_req_ready(d_rdy1), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rsp_valid(d_rv1), .d_rsp_data(d_rd1),
    .f_req_valid(f_req_valid), .f_req_ready(f_rdy1), .f_addr(f_addr), .f_rsp_valid(f_rv1),
    .f_rsp_data(f_rd1), .mem_we(we1), .mem_addr(a1), .mem_wdata(wd1), .mem_rdata(rd1)
  );

  // scoreboard: ids 0/1 = data/fetch of dut0, 2/3 = data/fetch of dut1
  task automatic chk_rsp(input int id, input logic v, input logic [31:0] d);
    int k = -1;
    if (v !== 1'b1) return;
    foreach (q[i]) if (k < 0 && q[i].id == id) k = i;
    total++;
    if (k < 0) begin
      bad++;
      $display("FAIL rsp%0d unexpected pulse data=%h at cyc %0d", id, d, cyc);
    end else begin
      if (q[k].d !== d || q[k].c != cyc) begin
        bad++;
        $display("FAIL rsp%0d got %h at cyc %0d, want %h at cyc %0d", id, d, cyc, q[k].d, q[k].c);
      end
      q.delete(k);
    end
  endtask

  always @(negedge clk) begin
    chk_rsp(0, d_rv0, {16'h0, d_rd0});
    chk_rsp(1, f_rv0, f_rd0);
    chk_rsp(2, d_rv1, {16'h0, d_rd1});
    chk_rsp(3, f_rv1, f_rd1);
  end

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    m0[a] <= v;
    m1[a] <= v;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (d_rdy0 && f_rdy0 && d_rdy1 && f_rdy1) return;
    end
    total++;
    bad++;
    $display("FAIL wait_idle timeout at cyc %0d", cyc);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want 0", q.size());
      q.delete();
    end
  endtask

  // one-cycle request on one channel; inputs are scrambled afterwards to prove sampling
  task automatic issue(input logic is_f, input logic we, input logic [15:0] a, input logic [15:0] wd,
                       output int t);
    wait_idle();
    t = cyc;
    if (is_f) begin
      f_req_valid = 1;
      f_addr = a;
    end else begin
      d_req_valid = 1;
      d_we = we;
      d_addr = a;
      d_wdata = wd;
    end
    @(posedge clk);
    #1;
    d_req_valid = 0;
    f_req_valid = 0;
    d_addr = 16'hDEAD;
    d_wdata = 16'hDEAD;
    f_addr = 16'hDEAD;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 2;
    if ({d_rdy0, f_rdy0, we0, d_rv0, f_rv0, a0, wd0, d_rd0, f_rd0} !== '0) begin
      bad++;
      $display("FAIL reset0 outputs not zero: rdy=%b%b we=%b addr=%h rsp=%h/%h", d_rdy0, f_rdy0, we0, a0, d_rd0, f_rd0);
    end
    if ({d_rdy1, f_rdy1, we1, d_rv1, f_rv1, a1, wd1, d_rd1, f_rd1} !== '0) begin
      bad++;
      $display("FAIL reset1 outputs not zero: rdy=%b%b we=%b addr=%h rsp=%h/%h", d_rdy1, f_rdy1, we1, a1, d_rd1, f_rd1);
    end
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    total++;
    if ({d_rdy0, f_rdy0, d_rdy1, f_rdy1} !== 4'hF) begin
      bad++;
      $display("FAIL reset_ready got %b want 1111", {d_rdy0, f_rdy0, d_rdy1, f_rdy1});
    end
  endtask

  task automatic test_load();
    int t;
    logic s0 = 0, s1 = 0;
    preload(16'h0010, 16'hBEEF);
    issue(0, 0, 16'h0010, 16'h0, t);
    q.push_back('{0, t + 3, 32'hBEEF});
    q.push_back('{2, t + 5, 32'hBEEF});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      s0 |= we0;
      s1 |= we1;
      if (k == 1) begin
        total++;
        if (a0 !== 16'h0010 || a1 !== 16'h0010) begin
          bad++;
          $display("FAIL load_addr got %h/%h want 0010", a0, a1);
        end
      end
    end
    total++;
    if ({s0, s1} !== 2'b00) begin
      bad++;
      $display("FAIL load_we got %b want 00", {s0, s1});
    end
    wait_drain();
  endtask

  task automatic test_store();
    int t;
    issue(0, 1, 16'h0020, 16'h1234, t);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      total++;
      if (we0 !== (k == 1) || we1 !== (k == 1)) begin
        bad++;
        $display("FAIL store_we cyc t+%0d got %b/%b want %b", k, we0, we1, k == 1);
      end
      if (k == 1) begin
        total++;
        if ({a0, wd0, a1, wd1} !== {16'h0020, 16'h1234, 16'h0020, 16'h1234}) begin
          bad++;
          $display("FAIL store_bus got %h:%h %h:%h want 0020:1234", a0, wd0, a1, wd1);
        end
      end
    end
    issue(0, 0, 16'h0020, 16'h0, t);
    q.push_back('{0, t + 3, 32'h1234});
    q.push_back('{2, t + 5, 32'h1234});
    wait_drain();
  endtask

  task automatic test_fetch(input logic [15:0] a, input logic [15:0] w0, input logic [15:0] w1);
    int t;
    preload(a, w0);
    preload(a + 16'h1, w1);
    issue(1, 0, a, 16'h0, t);
    q.push_back('{1, t + 4, {w1, w0}});
    q.push_back('{3, t + 6, {w1, w0}});
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      total++;
      if (a0 !== a + 16'(k - 1) || a1 !== a + 16'(k - 1) || we0 !== 1'b0) begin
        bad++;
        $display("FAIL fetch_addr t+%0d got %h/%h we=%b want %h", k, a0, a1, we0, a + 16'(k - 1));
      end
    end
    wait_drain();
  endtask

  task automatic test_arb();
    logic [3:0] g0 = 0, g1 = 0;
    int n0 = 0, n1 = 0;
    logic done = 0;
    wait_idle();
    d_we = 1;
    d_addr = 16'h0030;
    d_wdata = 16'h7777;
    f_addr = 16'h0100;
    d_req_valid = 1;
    f_req_valid = 1;
    #1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (d_rdy0) begin if (n0 < 4) g0[n0] = 0; n0++; end
      if (f_rdy0) begin if (n0 < 4) g0[n0] = 1; n0++; q.push_back('{1, cyc + 4, 32'h5555AAAA}); end
      if (d_rdy1) begin if (n1 < 4) g1[n1] = 0; n1++; end
      if (f_rdy1) begin if (n1 < 4) g1[n1] = 1; n1++; q.push_back('{3, cyc + 6, 32'h5555AAAA}); end
      @(posedge clk);
      #1;
      done = n0 >= 4 && n1 >= 4;
      if (!done) @(negedge clk);
    end
    d_req_valid = 0;
    f_req_valid = 0;
    total += 2;
    if (!done || g0 !== 4'b0000) begin
      bad++;
      $display("FAIL arb_fixed grants=%b n=%0d want 0000", g0, n0);
    end
    if (!done || g1 !== 4'b1010) begin
      bad++;
      $display("FAIL arb_fair grants=%b n=%0d want 1010", g1, n1);
    end
    wait_drain();
  endtask

  task automatic test_rst_mid_fetch();
    int t;
    logic s = 0;
    issue(1, 0, 16'h0100, 16'h0, t);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    total++;
    if ({we0, a0, we1, a1} !== '0 || {d_rdy0, f_rdy0, d_rdy1, f_rdy1} !== 4'hF) begin
      bad++;
      $display("FAIL rst_mid we=%b%b addr=%h/%h rdy=%b want 00 0000/0000 1111", we0, we1, a0, a1,
               {d_rdy0, f_rdy0, d_rdy1, f_rdy1});
    end
    for (int k = 0; k < 12; k++) begin
      s |= f_rv0 | f_rv1;
      @(negedge clk);
    end
    total++;
    if (s !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid f_rsp_valid seen=%b want 0", s);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_store();
    test_fetch(16'h0100, 16'hAAAA, 16'h5555);
    test_fetch(16'hFFFF, 16'h1111, 16'h2222);
    test_arb();
    test_rst_mid_fetch();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL final pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
